// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result queues, round-robin grant onto CDB_W lanes, FU stall.
// Define CDB_ARB_PERF_EN to add broadcast/stall/occupancy performance counters.
module cdb_arb_q #(
    parameter int QDEPTH = 4,
    parameter int EW     = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [EW-1:0]           din,
    output logic [EW-1:0]           head,
    output logic                    nempty,
    output logic                    drop,
    output logic [$clog2(QDEPTH):0] cnt_nxt
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [EW-1:0] mem_q [QDEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, pop_ok, push_ok;

    assign nempty  = (cnt_q != '0);
    assign full    = (cnt_q == CW'(QDEPTH));
    assign pop_ok  = pop && nempty && !flush;
    // A full queue still accepts a push when its head leaves in the same cycle.
    assign push_ok = push && !flush && (!full || pop_ok);
    assign drop    = push && !flush && full && !pop_ok;
    assign head    = mem_q[rd_q];
    assign cnt_nxt = cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush)                  cnt_d = '0;
        else if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
        else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (flush) begin
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                if (pop_ok)  rd_q <= rd_q + 1'b1;
                if (push_ok) wr_q <= wr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end
endmodule

module cdb_arbiter #(
    parameter int NUM_SRC = 5,
    parameter int CDB_W   = 3,
    parameter int QDEPTH  = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      fu_stall,
    output logic [CDB_W-1:0]          cdb_valid,
    output logic [CDB_W*TAG_W-1:0]    cdb_tag,
    output logic [CDB_W*DATA_W-1:0]   cdb_data,
`ifdef CDB_ARB_PERF_EN
    output logic [31:0]               perf_bcast_cnt,
    output logic [31:0]               perf_stall_cnt,
    output logic [$clog2(QDEPTH):0]   perf_maxocc,
`endif
    output logic                      overflow_err
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int EW = TAG_W + DATA_W;

    logic [NUM_SRC-1:0]          nempty, pop, drop;
    logic [NUM_SRC-1:0][EW-1:0]  head;
    logic [NUM_SRC-1:0][CW-1:0]  cnt_nxt;
    logic [PW-1:0]               rr_q, rr_d;
    logic [CDB_W-1:0]            lv;
    logic [CDB_W-1:0][EW-1:0]    le;
    logic                        stall_d;

    logic                        stall_q, ovf_q;
    logic [CDB_W-1:0]            vld_q;
    logic [CDB_W*TAG_W-1:0]      tag_q;
    logic [CDB_W*DATA_W-1:0]     data_q;

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_q
            cdb_arb_q #(.QDEPTH(QDEPTH), .EW(EW)) u_q (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .push    (src_valid[s]),
                .pop     (pop[s]),
                .din     ({src_tag[s*TAG_W +: TAG_W], src_data[s*DATA_W +: DATA_W]}),
                .head    (head[s]),
                .nempty  (nempty[s]),
                .drop    (drop[s]),
                .cnt_nxt (cnt_nxt[s])
            );
        end
    endgenerate

    // Scan from rr_q with wrap; lane n takes the n-th non-empty head found.
    always_comb begin
        int idx;
        int n;
        pop  = '0;
        lv   = '0;
        le   = '0;
        rr_d = rr_q;
        idx  = 0;
        n    = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!flush && nempty[idx] && n < CDB_W) begin
                pop[idx] = 1'b1;
                lv[n]    = 1'b1;
                le[n]    = head[idx];
                rr_d     = (idx == NUM_SRC - 1) ? '0 : PW'(idx + 1);
                n++;
            end
        end
    end

    // Stall one entry early so a result already in flight still has a slot.
    always_comb begin
        stall_d = 1'b0;
        for (int s = 0; s < NUM_SRC; s++)
            if (cnt_nxt[s] >= CW'(QDEPTH - 1)) stall_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= '0;
            vld_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rr_q    <= flush ? '0 : rr_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_q | (|drop);
            vld_q   <= lv;
            for (int k = 0; k < CDB_W; k++) begin
                tag_q[k*TAG_W +: TAG_W]    <= le[k][EW-1 -: TAG_W];
                data_q[k*DATA_W +: DATA_W] <= le[k][DATA_W-1:0];
            end
        end
    end

    assign cdb_valid    = vld_q;
    assign cdb_tag      = tag_q;
    assign cdb_data     = data_q;
    assign fu_stall     = stall_q;
    assign overflow_err = ovf_q;

`ifdef CDB_ARB_PERF_EN
    logic [31:0]   bcast_q, stallc_q, ngrant;
    logic [CW-1:0] maxocc_q, maxocc_d;

    always_comb begin
        ngrant   = '0;
        maxocc_d = maxocc_q;
        for (int k = 0; k < CDB_W; k++) ngrant = ngrant + 32'(lv[k]);
        for (int s = 0; s < NUM_SRC; s++)
            if (cnt_nxt[s] > maxocc_d) maxocc_d = cnt_nxt[s];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcast_q  <= '0;
            stallc_q <= '0;
            maxocc_q <= '0;
        end else begin
            bcast_q  <= (bcast_q > ~ngrant) ? '1 : bcast_q + ngrant;
            if (stall_q && stallc_q != '1) stallc_q <= stallc_q + 1'b1;
            maxocc_q <= maxocc_d;
        end
    end

    assign perf_bcast_cnt = bcast_q;
    assign perf_stall_cnt = stallc_q;
    assign perf_maxocc    = maxocc_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboarded bench for cdb_arbiter: expected results queued at drive time, matched on CDB.
module tb_cdb_arbiter;
    localparam int NS = 5;
    localparam int LW = 3;
    localparam int TW = 6;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [NS-1:0]     src_valid;
    logic [NS*TW-1:0]  src_tag;
    logic [NS*DW-1:0]  src_data;
    logic              fu_stall;
    logic [LW-1:0]     cdb_valid;
    logic [LW*TW-1:0]  cdb_tag;
    logic [LW*DW-1:0]  cdb_data;
    logic              overflow_err;

    cdb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .src_valid    (src_valid),
        .src_tag      (src_tag),
        .src_data     (src_data),
        .fu_stall     (fu_stall),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    src;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t       sbq[$];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         sb_en = 1'b0;
    logic [5:0] tag_ctr = '0;
    int         seq = 0;
    int         midx;
    bit         mold;

    function automatic logic [TW-1:0] ltag(input int k);
        return cdb_tag[k*TW +: TW];
    endfunction
    function automatic logic [DW-1:0] ldat(input int k);
        return cdb_data[k*DW +: DW];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src_valid = '0;
        src_tag   = '0;
        src_data  = '0;
    endtask

    task automatic put(input int s, input logic [TW-1:0] t, input logic [DW-1:0] d, input bit track);
        src_valid[s]          = 1'b1;
        src_tag[s*TW +: TW]   = t;
        src_data[s*DW +: DW]  = d;
        if (track) sbq.push_back('{src: 3'(s), tag: t, data: d});
    endtask

    task automatic put_all(input bit track);
        for (int s = 0; s < NS; s++) begin
            put(s, tag_ctr, {8'(s), 24'(seq)}, track);
            tag_ctr++;
            seq++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        sbq.delete();
    endtask

    // Every broadcast must match the oldest outstanding result of some source.
    always @(negedge clk) begin
        if (!rst && sb_en) begin
            n_cmp++;
            if (!(cdb_valid inside {3'b000, 3'b001, 3'b011, 3'b111})) begin
                n_err++;
                $display("FAIL lane_pack: got valid %b, expected lanes filled from lane0", cdb_valid);
            end
            for (int k = 0; k < LW; k++) begin
                if (cdb_valid[k]) begin
                    midx = -1;
                    for (int i = 0; i < sbq.size(); i++)
                        if (midx < 0 && sbq[i].tag == ltag(k) && sbq[i].data == ldat(k)) midx = i;
                    n_cmp++;
                    if (midx < 0) begin
                        n_err++;
                        $display("FAIL cdb_match lane%0d: got tag %0d data %h, expected an outstanding result",
                                 k, ltag(k), ldat(k));
                    end else begin
                        mold = 1'b0;
                        for (int i = 0; i < midx; i++) if (sbq[i].src == sbq[midx].src) mold = 1'b1;
                        n_cmp++;
                        if (mold) begin
                            n_err++;
                            $display("FAIL fifo_order lane%0d: got tag %0d, expected older entry of src %0d first",
                                     k, ltag(k), sbq[midx].src);
                        end
                        sbq.delete(midx);
                    end
                end else begin
                    n_cmp++;
                    if (ltag(k) !== '0 || ldat(k) !== '0) begin
                        n_err++;
                        $display("FAIL idle_lane%0d: got tag %h data %h, expected 0", k, ltag(k), ldat(k));
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        idle();
        repeat (3) cyc();
        n_cmp++;
        if ({cdb_valid, cdb_tag, cdb_data, fu_stall, overflow_err} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got valid %b stall %b ovf %b, expected all 0", cdb_valid, fu_stall, overflow_err);
        end
        rst = 1'b0;
        sb_en = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        put(2, 6'd5, 32'hDEAD, 1'b1);
        cyc();
        idle();
        n_cmp++;
        if (cdb_valid !== 3'b000) begin
            n_err++;
            $display("FAIL no_bypass: got valid %b, expected 000", cdb_valid);
        end
        cyc();
        n_cmp++;
        if (cdb_valid !== 3'b001 || ltag(0) !== 6'd5 || ldat(0) !== 32'hDEAD) begin
            n_err++;
            $display("FAIL single: got valid %b tag %0d data %h, expected 001 5 0000dead", cdb_valid, ltag(0), ldat(0));
        end
        cyc();
    endtask

    // rr_ptr is 3 after the single result on source 2.
    task automatic test_rr_wrap();
        logic [5:0] b;
        b = tag_ctr;
        put_all(1'b1);
        cyc();
        idle();
        cyc();
        n_cmp++;
        if (cdb_valid !== 3'b111 || ltag(0) !== 6'(b + 3) || ltag(1) !== 6'(b + 4) || ltag(2) !== b) begin
            n_err++;
            $display("FAIL rr_wrap_1: got valid %b tags %0d %0d %0d, expected 111 %0d %0d %0d",
                     cdb_valid, ltag(0), ltag(1), ltag(2), 6'(b + 3), 6'(b + 4), b);
        end
        cyc();
        n_cmp++;
        if (cdb_valid !== 3'b011 || ltag(0) !== 6'(b + 1) || ltag(1) !== 6'(b + 2)) begin
            n_err++;
            $display("FAIL rr_wrap_2: got valid %b tags %0d %0d, expected 011 %0d %0d",
                     cdb_valid, ltag(0), ltag(1), 6'(b + 1), 6'(b + 2));
        end
        cyc();
    endtask

    task automatic test_five();
        do_reset();
        cyc();
        tag_ctr = 6'd10;
        put_all(1'b1);
        cyc();
        idle();
        cyc();
        n_cmp++;
        if (cdb_valid !== 3'b111 || ltag(0) !== 6'd10 || ltag(1) !== 6'd11 || ltag(2) !== 6'd12) begin
            n_err++;
            $display("FAIL five_1: got valid %b tags %0d %0d %0d, expected 111 10 11 12",
                     cdb_valid, ltag(0), ltag(1), ltag(2));
        end
        cyc();
        n_cmp++;
        if (cdb_valid !== 3'b011 || ltag(0) !== 6'd13 || ltag(1) !== 6'd14) begin
            n_err++;
            $display("FAIL five_2: got valid %b tags %0d %0d, expected 011 13 14", cdb_valid, ltag(0), ltag(1));
        end
        cyc();
        n_cmp++;
        if (cdb_valid !== 3'b000) begin
            n_err++;
            $display("FAIL five_3: got valid %b, expected 000", cdb_valid);
        end
    endtask

    // All sources push while the bench honours fu_stall; source 4 reaches 3 at the 4th push.
    task automatic test_stall();
        int n_push;
        int first;
        n_push = 0;
        first  = -1;
        for (int c = 0; c < 12; c++) begin
            if (!fu_stall) begin
                put_all(1'b1);
                n_push++;
            end else begin
                idle();
            end
            cyc();
            if (fu_stall && first < 0) first = n_push;
        end
        idle();
        for (int i = 0; i < 30 && sbq.size() != 0; i++) cyc();
        cyc();
        n_cmp++;
        if (first !== 4) begin
            n_err++;
            $display("FAIL stall_onset: got first stall after %0d pushes, expected 4", first);
        end
        n_cmp++;
        if (overflow_err !== 1'b0 || fu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL stall_drain: got ovf %b stall %b, expected 0 0", overflow_err, fu_stall);
        end
        n_cmp++;
        if (sbq.size() !== 0) begin
            n_err++;
            $display("FAIL stall_lost: got %0d undelivered results, expected 0", sbq.size());
        end
    endtask

    task automatic test_flush();
        logic [5:0] b;
        do_reset();
        cyc();
        for (int i = 0; i < 6; i++) begin
            put_all(1'b1);
            cyc();
        end
        n_cmp++;
        if (fu_stall !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre_stall: got %b, expected 1", fu_stall);
        end
        flush = 1'b1;
        put_all(1'b0);
        cyc();
        flush = 1'b0;
        idle();
        sbq.delete();
        n_cmp++;
        if (cdb_valid !== 3'b000 || fu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_next: got valid %b stall %b, expected 000 0", cdb_valid, fu_stall);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++;
            if (cdb_valid !== 3'b000) begin
                n_err++;
                $display("FAIL flush_empty: got valid %b, expected 000", cdb_valid);
            end
        end
        b = tag_ctr;
        put_all(1'b1);
        cyc();
        idle();
        cyc();
        n_cmp++;
        if (ltag(0) !== b || ltag(2) !== 6'(b + 2)) begin
            n_err++;
            $display("FAIL flush_rr: got lane0 %0d lane2 %0d, expected %0d %0d", ltag(0), ltag(2), b, 6'(b + 2));
        end
        for (int i = 0; i < 10 && sbq.size() != 0; i++) cyc();
        cyc();
    endtask

    // rr_ptr is left at 2, so under a full storm source 1 is the first full-and-ungranted queue (9th push).
    task automatic test_overflow();
        do_reset();
        cyc();
        put(1, tag_ctr, 32'h0001_0000, 1'b1);
        tag_ctr++;
        cyc();
        idle();
        cyc();
        cyc();
        sb_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            put_all(1'b0);
            cyc();
        end
        n_cmp++;
        if (overflow_err !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_early: got %b, expected 0", overflow_err);
        end
        put_all(1'b0);
        cyc();
        n_cmp++;
        if (overflow_err !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: got %b, expected 1", overflow_err);
        end
        flush = 1'b1;
        put_all(1'b0);
        cyc();
        flush = 1'b0;
        idle();
        sbq.delete();
        sb_en = 1'b1;
        repeat (3) cyc();
        n_cmp++;
        if (overflow_err !== 1'b1 || cdb_valid !== 3'b000) begin
            n_err++;
            $display("FAIL ovf_sticky: got ovf %b valid %b, expected 1 000", overflow_err, cdb_valid);
        end
        do_reset();
        cyc();
        n_cmp++;
        if (overflow_err !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b, expected 0", overflow_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] b;
        put_all(1'b1);
        cyc();
        idle();
        cyc();
        n_cmp++;
        if (cdb_valid !== 3'b111) begin
            n_err++;
            $display("FAIL rstmid_pre: got valid %b, expected 111", cdb_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (cdb_valid !== 3'b000 || fu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: got valid %b stall %b, expected 000 0", cdb_valid, fu_stall);
        end
        sbq.delete();
        #2 rst = 1'b0;
        repeat (3) cyc();
        n_cmp++;
        if (cdb_valid !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_empty: got valid %b, expected 000", cdb_valid);
        end
        b = tag_ctr;
        put_all(1'b1);
        cyc();
        idle();
        cyc();
        n_cmp++;
        if (cdb_valid !== 3'b111 || ltag(0) !== b) begin
            n_err++;
            $display("FAIL rstmid_rr: got valid %b lane0 %0d, expected 111 %0d", cdb_valid, ltag(0), b);
        end
        for (int i = 0; i < 10 && sbq.size() != 0; i++) cyc();
        cyc();
        n_cmp++;
        if (sbq.size() !== 0) begin
            n_err++;
            $display("FAIL rstmid_lost: got %0d undelivered results, expected 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_wrap();
        test_five();
        test_stall();
        test_flush();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits directly downstream of the unified functional-unit block.
- Per cycle, captures up to NUM_SRC completed results (ALU slots first, then MulDiv slots) into small per-source queues.
- Round-robin arbitrates them onto a CDB_W-wide common data bus feeding the RS wakeup logic and the completion buffer.
- Generates the stall that holds the functional units when any queue nears full.

Parameters:
- NUM_SRC, 5, number of result sources (no_ALU_units + 2*no_MulDiv_units).
- CDB_W, 3, CDB broadcast lanes per cycle.
- QDEPTH, 4, entries per source queue (power of two, >=2).
- TAG_W, 6, ROB tag width.
- DATA_W, 32, result data width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; asynchronous, active-high.
- flush, in, 1, pipeline flush.
- src_valid, in, NUM_SRC, per-source result valid.
- src_tag, in, NUM_SRC*TAG_W, per-source ROB tag.
- src_data, in, NUM_SRC*DATA_W, per-source result.
- fu_stall, out, 1, stall to functional units.
- cdb_valid, out, CDB_W, lane valid.
- cdb_tag, out, CDB_W*TAG_W, lane tag.
- cdb_data, out, CDB_W*DATA_W, lane data.
- overflow_err, out, 1, sticky protocol-violation flag.

Behaviour:
- Reset (async, active-high): all queues empty, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, fu_stall=0, overflow_err=0.
- Enqueue: on each rising edge, every source with src_valid=1 pushes {tag,data} into its own queue. At most one push per source per cycle.
- Grant: combinational on queue heads only, at most one entry per source per cycle. Scan sources starting at rr_ptr, wrapping modulo NUM_SRC; grant the first CDB_W non-empty queues.
  - Lane k carries the k-th grant in scan order. Unused lanes get valid=0, tag=0, data=0.
- Output: grants are popped and registered onto the cdb_* outputs at the same edge.
  - Latency: src_valid high in cycle N → entry in queue during N+1 → earliest cdb_valid in cycle N+2.
  - No bypass from src to cdb.
- rr_ptr update: becomes (last granted source index + 1) mod NUM_SRC; unchanged if nothing was granted.
- Simultaneous push and pop on the same queue: legal. Count is unchanged; the head advances and the new entry goes to the tail.
- Wrap-around: read/write pointers are log2(QDEPTH) bits and wrap naturally. Count is log2(QDEPTH)+1 bits.
- fu_stall: registered.
  - Asserted for the next cycle when any queue's post-update count >= QDEPTH-1. This guarantees room for the one result that may already be in flight while the FUs see the stall.
  - Deasserted once all post-update counts <= QDEPTH-2.
- Full queue: a push to a full queue that is not popped in the same cycle is dropped and sets overflow_err=1. overflow_err clears only on rst; flush does not clear it.
- Flush: synchronous and takes priority over everything else in that cycle.
  - All queues emptied and rr_ptr=0.
  - cdb_valid=0 on the next cycle; no grants issued that cycle.
  - fu_stall=0 on the next cycle.
  - src_valid in the flush cycle is ignored.
- Reset mid-operation: all state is cleared asynchronously. Queued results are discarded with no CDB broadcast.
- Ordering: FIFO order is preserved within a source. No ordering is guaranteed across sources.

Optional Feature:
- Macro: CDB_ARB_PERF_EN.
- When defined, adds three outputs:
  - perf_bcast_cnt (32b): total CDB grants, +popcount(cdb grants) per cycle.
  - perf_stall_cnt (32b): cycles with fu_stall=1.
  - perf_maxocc (log2(QDEPTH)+1 bits): high-water mark of any queue's count.
- Counters saturate at all-ones. They reset on rst only; flush does not clear them.
- When not defined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Single result: source 2 valid, tag=5, data=0xDEAD in cycle 1 → cycle 3: lane0 valid, tag=5, data=0xDEAD; lanes1-2 invalid; rr_ptr=3.
- Five sources valid in one cycle, tags 10-14, rr_ptr=0 → next cycle lanes carry tags 10,11,12; the following cycle lanes0-1 carry 13,14 and rr_ptr=0.
- Source 4 pushes each cycle while sources 0-3 push continuously (QDEPTH=4) → fu_stall=1 the cycle after source 4's count reaches 3; no overflow_err; source 4 drains in FIFO order.
- Push source 1 while its queue is full and not granted (forced by bench) → entry dropped, overflow_err=1 and stays high through a flush, clears only on rst.
- Queues hold 3 entries and flush=1 together with src_valid=all-ones → next cycle cdb_valid=0, fu_stall=0, all queues empty; no flushed tag ever appears on the CDB.
- Assert rst asynchronously mid-cycle while cdb_valid=3'b111 → cdb_valid=0 immediately, before the next clock edge; after release, rr_ptr=0 and queues are empty.
